packet_parser: RTL and testbench

Parse-task engine for the CRC8 packet-processing subsystem. On `start` it reads a packet from the 32-bit output memory and reports the results to the parse register block (`pp_*` fields). It decodes and corrects the header with Hamming SEC and detects uncorrectable errors. It recomputes CRC8 over the payload and compares it with the stored CRC byte, making it the receiving counterpart of the packet builder.

---
 rtl/pp_pkg.sv | 37 +++
 rtl/crc8_byte.sv | 21 ++
 rtl/packet_parser.sv | 222 ++++++++++++++++++++++
 tb/tb_packet_parser.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/pp_pkg.sv
// Shared definitions for the packet parser: header layout, CRC default,
// FSM state encoding, Hamming(12,8) parity generation and syndrome classes.
package pp_pkg;

    // Bit offsets of header fields inside the first memory word
    localparam int HDR_CNT_LSB  = 0;
    localparam int HDR_TYPE_LSB = 4;
    localparam int HDR_ECC_LSB  = 8;
    localparam int HDR_SOP_LSB  = 12;

    localparam logic [7:0] PP_CRC_POLY = 8'h07;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR_RD,
        ST_HDR_CHK,
        ST_PLD_RD,
        ST_CRC_CHK,
        ST_DONE
    } pp_state_e;

    // Syndrome classification of the header codeword
    localparam logic [1:0] SYN_NONE   = 2'd0;
    localparam logic [1:0] SYN_CORR   = 2'd1;
    localparam logic [1:0] SYN_UNCORR = 2'd2;

    // Parity bits {p8,p4,p2,p1} for data d0..d7 at positions 3,5,6,7,9,10,11,12
    function automatic logic [3:0] ham_ecc(input logic [7:0] d);
        logic p1, p2, p4, p8;
        p1 = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6];
        p2 = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6];
        p4 = d[1] ^ d[2] ^ d[3] ^ d[7];
        p8 = d[4] ^ d[5] ^ d[6] ^ d[7];
        return {p8, p4, p2, p1};
    endfunction

endpackage

// File: rtl/crc8_byte.sv
// One-byte CRC8 step: MSB-first, no reflection. Purely combinational so the
// same block can sit in both the builder and the parser datapaths.
module crc8_byte #(
    parameter logic [7:0] POLY = 8'h07
) (
    input  logic [7:0] crc_i,
    input  logic [7:0] data_i,
    output logic [7:0] crc_o
);

    // Fold the byte into the CRC eight bits at a time
    always_comb begin
        logic [7:0] c;
        c = crc_i ^ data_i;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ POLY) : (c << 1);
        end
        crc_o = c;
    end

endmodule

// File: rtl/packet_parser.sv
// Packet parse engine: reads a header word, Hamming-corrects it, streams the
// payload bytes through CRC8 and compares against the stored CRC byte.
// Build option PP_CRC_CHK_EN: when undefined the CRC datapath and CRC_CHK
// state are absent, payload streaming ends at the last payload byte and
// pkt_crc_err stays 0.
module packet_parser
    import pp_pkg::*;
#(
    parameter int         ADDR_W   = 14,
    parameter int         DATA_W   = 32,
    parameter logic [7:0] CRC_POLY = PP_CRC_POLY
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [31:0]       addr_hdr,
    input  logic              ignore_ecc_err,
    output logic              busy,
    output logic              irq,
    output logic              pkt_ecc_corr,
    output logic              pkt_ecc_uncorr,
    output logic              pkt_crc_err,
    output logic [3:0]        pkt_byte_cnt,
    output logic [3:0]        pkt_type,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data_i
);

    pp_state_e         state_q;
    logic [ADDR_W-1:0] addr_q;
    logic              ign_q;
    logic              busy_q, irq_q, corr_q, uncorr_q, crc_err_q;
    logic [3:0]        cnt_q, type_q;
    logic              mem_en_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [4:0]        k_q;        // byte index within the packet stream
    logic [2:0]        widx_q;     // word index of the buffered word
    logic              rd_pend_q;  // memory data is valid this cycle

    logic [7:0] hdr_raw, hdr_fix_d;
    logic [3:0] syn_d;
    logic [1:0] syn_cls_d;
    logic       have_byte;
    logic [4:0] last_k;

    logic unused_addr;
    assign unused_addr = ^addr_hdr[31:ADDR_W];

    assign hdr_raw   = mem_data_i[HDR_CNT_LSB +: 8];
    assign syn_d     = ham_ecc(hdr_raw) ^ mem_data_i[HDR_ECC_LSB +: 4];
    assign have_byte = rd_pend_q || (k_q[4:2] == widx_q);

`ifdef PP_CRC_CHK_EN
    logic [DATA_W-1:0] word_q;
    logic [DATA_W-1:0] src_word;
    logic [7:0]        lane_w [4];
    logic [7:0]        cur_byte, crc_q, crc_d, crc_stored_q;

    assign last_k   = 5'd3 + {1'b0, cnt_q};
    assign src_word = rd_pend_q ? mem_data_i : word_q;
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign lane_w[gi] = src_word[8*gi +: 8];
    end
    assign cur_byte = lane_w[k_q[1:0]];

    crc8_byte #(.POLY(CRC_POLY)) u_crc (
        .crc_i  (crc_q),
        .data_i (cur_byte),
        .crc_o  (crc_d)
    );
`else
    logic unused_data;
    assign unused_data = ^{mem_data_i[DATA_W-1:12], CRC_POLY};
    assign last_k      = 5'd2 + {1'b0, cnt_q};
`endif

    // Header syndrome decode: correct single data-bit errors in place
    always_comb begin
        hdr_fix_d = hdr_raw;
        syn_cls_d = SYN_NONE;
        case (syn_d)
            4'd0:                   syn_cls_d = SYN_NONE;
            4'd1, 4'd2, 4'd4, 4'd8: syn_cls_d = SYN_CORR;
            4'd3:  begin hdr_fix_d[0] = ~hdr_raw[0]; syn_cls_d = SYN_CORR; end
            4'd5:  begin hdr_fix_d[1] = ~hdr_raw[1]; syn_cls_d = SYN_CORR; end
            4'd6:  begin hdr_fix_d[2] = ~hdr_raw[2]; syn_cls_d = SYN_CORR; end
            4'd7:  begin hdr_fix_d[3] = ~hdr_raw[3]; syn_cls_d = SYN_CORR; end
            4'd9:  begin hdr_fix_d[4] = ~hdr_raw[4]; syn_cls_d = SYN_CORR; end
            4'd10: begin hdr_fix_d[5] = ~hdr_raw[5]; syn_cls_d = SYN_CORR; end
            4'd11: begin hdr_fix_d[6] = ~hdr_raw[6]; syn_cls_d = SYN_CORR; end
            4'd12: begin hdr_fix_d[7] = ~hdr_raw[7]; syn_cls_d = SYN_CORR; end
            default:                syn_cls_d = SYN_UNCORR;
        endcase
    end

    // Task sequencer with all outputs registered
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            ign_q      <= 1'b0;
            busy_q     <= 1'b0;
            irq_q      <= 1'b0;
            corr_q     <= 1'b0;
            uncorr_q   <= 1'b0;
            crc_err_q  <= 1'b0;
            cnt_q      <= '0;
            type_q     <= '0;
            mem_en_q   <= 1'b0;
            mem_addr_q <= '0;
            k_q        <= '0;
            widx_q     <= '0;
            rd_pend_q  <= 1'b0;
`ifdef PP_CRC_CHK_EN
            word_q       <= '0;
            crc_q        <= '0;
            crc_stored_q <= '0;
`endif
        end else begin
            irq_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        addr_q     <= addr_hdr[ADDR_W-1:0];
                        ign_q      <= ignore_ecc_err;
                        busy_q     <= 1'b1;
                        corr_q     <= 1'b0;
                        uncorr_q   <= 1'b0;
                        crc_err_q  <= 1'b0;
                        cnt_q      <= '0;
                        type_q     <= '0;
                        mem_en_q   <= 1'b1;
                        mem_addr_q <= addr_hdr[ADDR_W-1:0];
                        state_q    <= ST_HDR_RD;
                    end
                end
                ST_HDR_RD: begin
                    mem_en_q <= 1'b0;
                    state_q  <= ST_HDR_CHK;
                end
                ST_HDR_CHK: begin
                    type_q    <= hdr_fix_d[HDR_TYPE_LSB +: 4];
                    cnt_q     <= hdr_fix_d[HDR_CNT_LSB +: 4];
                    corr_q    <= (syn_cls_d == SYN_CORR);
                    uncorr_q  <= (syn_cls_d == SYN_UNCORR);
                    k_q       <= 5'd2;
                    widx_q    <= '0;
                    rd_pend_q <= 1'b0;
`ifdef PP_CRC_CHK_EN
                    word_q    <= mem_data_i;
                    crc_q     <= '0;
`endif
                    if (syn_cls_d == SYN_UNCORR && !ign_q) begin
                        irq_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_DONE;
                    end else begin
                        state_q <= ST_PLD_RD;
                    end
                end
                ST_PLD_RD: begin
                    if (have_byte) begin
                        if (rd_pend_q) begin
                            rd_pend_q <= 1'b0;
                            widx_q    <= k_q[4:2];
`ifdef PP_CRC_CHK_EN
                            word_q    <= mem_data_i;
`endif
                        end
                        if (k_q == last_k) begin
`ifdef PP_CRC_CHK_EN
                            crc_stored_q <= cur_byte;
                            state_q      <= ST_CRC_CHK;
`else
                            irq_q   <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= ST_DONE;
`endif
                        end else begin
`ifdef PP_CRC_CHK_EN
                            crc_q <= crc_d;
`endif
                            k_q <= k_q + 5'd1;
                        end
                    end else if (mem_en_q) begin
                        mem_en_q  <= 1'b0;
                        rd_pend_q <= 1'b1;
                    end else begin
                        mem_en_q   <= 1'b1;
                        mem_addr_q <= addr_q + ADDR_W'(k_q[4:2]);
                    end
                end
`ifdef PP_CRC_CHK_EN
                ST_CRC_CHK: begin
                    crc_err_q <= (crc_q != crc_stored_q);
                    irq_q     <= 1'b1;
                    busy_q    <= 1'b0;
                    state_q   <= ST_DONE;
                end
`endif
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy           = busy_q;
    assign irq            = irq_q;
    assign pkt_ecc_corr   = corr_q;
    assign pkt_ecc_uncorr = uncorr_q;
    assign pkt_crc_err    = crc_err_q;
    assign pkt_byte_cnt   = cnt_q;
    assign pkt_type       = type_q;
    assign mem_en         = mem_en_q;
    assign mem_addr       = mem_addr_q;

endmodule

// File: tb/tb_packet_parser.sv
// Directed bench for packet_parser: hand-computed header/CRC vectors, a
// one-cycle-latency memory model, and irq/read counters.
module tb_packet_parser;

`ifdef PP_CRC_CHK_EN
    localparam bit CRC_EN = 1'b1;
`else
    localparam bit CRC_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] addr_hdr = 32'h0;
    logic        ignore_ecc_err = 1'b0;
    logic        busy, irq, pkt_ecc_corr, pkt_ecc_uncorr, pkt_crc_err;
    logic [3:0]  pkt_byte_cnt, pkt_type;
    logic        mem_en;
    logic [13:0] mem_addr;
    logic [31:0] mem_data_i = 32'h0;

    logic [31:0] mem [16];
    int n_checks = 0;
    int n_pass   = 0;
    int irq_cnt  = 0;
    int rd_cnt   = 0;

    packet_parser dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .addr_hdr       (addr_hdr),
        .ignore_ecc_err (ignore_ecc_err),
        .busy           (busy),
        .irq            (irq),
        .pkt_ecc_corr   (pkt_ecc_corr),
        .pkt_ecc_uncorr (pkt_ecc_uncorr),
        .pkt_crc_err    (pkt_crc_err),
        .pkt_byte_cnt   (pkt_byte_cnt),
        .pkt_type       (pkt_type),
        .mem_en         (mem_en),
        .mem_addr       (mem_addr),
        .mem_data_i     (mem_data_i)
    );

    always #5 clk = ~clk;

    // Memory model: data one cycle after mem_en, only words 0..15 populated
    always @(posedge clk) begin
        if (mem_en) mem_data_i <= (mem_addr[13:4] == 10'd0) ? mem[mem_addr[3:0]] : 32'h0;
    end

    // Event counters sampled mid-cycle
    always @(negedge clk) begin
        if (!reset) begin
            if (irq)    irq_cnt++;
            if (mem_en) rd_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    // Launch one parse task; optionally poke start while busy and in DONE
    task automatic run_pkt(input string name, input logic [31:0] w0, input logic [31:0] w1,
                           input logic ign, input bit poke, input int exp_reads);
        int cyc;
        int irq0;
        int rd0;
        mem[4] = w0;
        mem[5] = w1;
        irq0 = irq_cnt;
        rd0  = rd_cnt;
        @(negedge clk);
        start = 1'b1;
        addr_hdr = 32'hABCD_0004;
        ignore_ecc_err = ign;
        @(negedge clk);
        start = 1'b0;
        check({name, ".busy"}, 32'(busy), 32'd1);
        if (poke) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        cyc = 0;
        while (!irq && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check({name, ".irq"}, 32'(irq), 32'd1);
        check({name, ".busy_done"}, 32'(busy), 32'd0);
        if (poke) begin
            start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        repeat (10) @(negedge clk);
        check({name, ".irq_cnt"}, 32'(irq_cnt - irq0), 32'd1);
        check({name, ".reads"}, 32'(rd_cnt - rd0), 32'(exp_reads));
        check({name, ".busy_idle"}, 32'(busy), 32'd0);
    endtask

    task automatic chk_res(input string name, input logic corr, input logic uncorr,
                           input logic crc, input logic [3:0] cnt, input logic [3:0] typ);
        check({name, ".corr"},   32'(pkt_ecc_corr),   32'(corr));
        check({name, ".uncorr"}, 32'(pkt_ecc_uncorr), 32'(uncorr));
        check({name, ".crc"},    32'(pkt_crc_err),    32'(crc));
        check({name, ".cnt"},    32'(pkt_byte_cnt),   32'(cnt));
        check({name, ".type"},   32'(pkt_type),       32'(typ));
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'hDEAD_0000 | 32'(i);

        repeat (3) @(negedge clk);
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.irq", 32'(irq), 32'd0);
        check("rst.mem_en", 32'(mem_en), 32'd0);
        check("rst.mem_addr", 32'(mem_addr), 32'd0);
        chk_res("rst", 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
        reset = 1'b0;

        // Clean: type 2, cnt 1, payload 01 02, CRC 1B
        run_pkt("clean", 32'h0201_0921, 32'h0000_001B, 1'b0, 1'b0, CRC_EN ? 2 : 1);
        chk_res("clean", 1'b0, 1'b0, 1'b0, 4'd1, 4'd2);

        // d0 flipped: syndrome 3, corrected back to 0x21
        run_pkt("d0err", 32'h0201_0920, 32'h0000_001B, 1'b0, 1'b0, CRC_EN ? 2 : 1);
        chk_res("d0err", 1'b1, 1'b0, 1'b0, 4'd1, 4'd2);

        // p1 flipped: syndrome 1, data unchanged
        run_pkt("p1err", 32'h0201_0821, 32'h0000_001B, 1'b0, 1'b0, CRC_EN ? 2 : 1);
        chk_res("p1err", 1'b1, 1'b0, 1'b0, 4'd1, 4'd2);

        // Syndrome 15, abort after header read
        run_pkt("uncorr", 32'h0201_0621, 32'h0000_001B, 1'b0, 1'b0, 1);
        chk_res("uncorr", 1'b0, 1'b1, 1'b0, 4'd1, 4'd2);

        // Syndrome 15, ignored: raw header used, full parse
        run_pkt("uncign", 32'h0201_0621, 32'h0000_001B, 1'b1, 1'b0, CRC_EN ? 2 : 1);
        chk_res("uncign", 1'b0, 1'b1, 1'b0, 4'd1, 4'd2);

        // Stored CRC wrong
        run_pkt("crcerr", 32'h0201_0921, 32'h0000_001C, 1'b0, 1'b0, CRC_EN ? 2 : 1);
        chk_res("crcerr", 1'b0, 1'b0, CRC_EN, 4'd1, 4'd2);

        // Type 5, cnt 2: payload 01 02 03 spans two words, CRC 48
        run_pkt("two_word", 32'h0201_0752, 32'h0000_4803, 1'b0, 1'b0, 2);
        chk_res("two_word", 1'b0, 1'b0, 1'b0, 4'd2, 4'd5);

        // Reset while in PLD_RD, then restart the clean packet
        mem[4] = 32'h0201_0921;
        mem[5] = 32'h0000_001B;
        begin
            int irq0;
            irq0 = irq_cnt;
            @(negedge clk);
            start = 1'b1;
            addr_hdr = 32'h0000_0004;
            ignore_ecc_err = 1'b0;
            @(negedge clk);
            start = 1'b0;
            @(negedge clk);
            @(negedge clk);
            check("mid.type", 32'(pkt_type), 32'd2);
            check("mid.busy", 32'(busy), 32'd1);
            reset = 1'b1;
            @(negedge clk);
            check("midrst.busy", 32'(busy), 32'd0);
            check("midrst.irq", 32'(irq), 32'd0);
            check("midrst.mem_en", 32'(mem_en), 32'd0);
            check("midrst.mem_addr", 32'(mem_addr), 32'd0);
            chk_res("midrst", 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
            @(negedge clk);
            reset = 1'b0;
            repeat (5) @(negedge clk);
            check("midrst.no_irq", 32'(irq_cnt - irq0), 32'd0);
        end
        run_pkt("restart", 32'h0201_0921, 32'h0000_001B, 1'b0, 1'b0, CRC_EN ? 2 : 1);
        chk_res("restart", 1'b0, 1'b0, 1'b0, 4'd1, 4'd2);

        // start while busy and in the DONE cycle must be ignored
        run_pkt("poke", 32'h0201_0752, 32'h0000_4803, 1'b0, 1'b1, 2);
        chk_res("poke", 1'b0, 1'b0, 1'b0, 4'd2, 4'd5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
